// File: rtl/mc_main_fsm_pkg.sv
// Shared state encoding, datapath select codes and opcode classes for the multicycle control FSM.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP      = 2'b00;
    localparam logic [1:0] OP_MEM     = 2'b01;
    localparam logic [1:0] OP_BR      = 2'b10;

    // TST/TEQ/CMP/CMN only set flags and never write a register.
    function automatic logic is_compare(input logic [5:0] funct);
        return funct[4:3] == 2'b10;
    endfunction

endpackage

// File: rtl/mc_main_fsm_if.sv
// Instruction fields and memory handshake in, datapath selects and enables out.
interface mc_main_fsm_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic       CondEx;
    logic       MemReady;
    logic       IRWrite;
    logic       AdrSrc;
    logic       MemW;
    logic       RegW;
    logic       NextPC;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       FlagEn;
    logic       Branch;
    logic       Busy;
    logic       Fault;
    logic [3:0] State;

    modport master (
        input  Op, Funct, Rd, CondEx, MemReady,
        output IRWrite, AdrSrc, MemW, RegW, NextPC, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, FlagEn, Branch, Busy, Fault, State
    );

    modport slave (
        output Op, Funct, Rd, CondEx, MemReady,
        input  IRWrite, AdrSrc, MemW, RegW, NextPC, ALUSrcA, ALUSrcB, ResultSrc,
               ALUOp, FlagEn, Branch, Busy, Fault, State
    );
endinterface

// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle core: sequences fetch/decode/execute/memory/write-back.
// Latency: outputs are combinational from the current state and inputs; one state per cycle.
// Backpressure: stalls in FETCH/MEMREAD/MEMWRITE until MemReady, faulting after WAIT_LIMIT busy cycles.
import mc_ctrl_pkg::*;

module mc_main_fsm #(
    parameter int WAIT_LIMIT = 16,
    parameter int CNT_W      = 5
) (
    input  logic          clk,
    input  logic          reset,
    mc_main_fsm_if.master bus
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(WAIT_LIMIT);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
    logic             timeout;
    logic             busy;
    logic             unused_funct;

    assign unused_funct = ^bus.Funct[2:1];

    // Saturating increment; the fault decision looks at the count this busy cycle would reach.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
    assign timeout = (WAIT_LIMIT != 0) && (cnt_inc >= LIMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next    = state;
        busy          = 1'b0;
        bus.IRWrite   = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.MemW      = 1'b0;
        bus.RegW      = 1'b0;
        bus.NextPC    = 1'b0;
        bus.ALUSrcA   = 1'b0;
        bus.ALUSrcB   = SRCB_REG;
        bus.ResultSrc = RES_ALUOUT;
        bus.ALUOp     = 1'b0;
        bus.FlagEn    = 1'b0;
        bus.Branch    = 1'b0;
        bus.Fault     = 1'b0;

        case (state)
            S_FETCH: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALU;
                if (bus.MemReady) begin
                    bus.IRWrite = 1'b1;
                    bus.NextPC  = 1'b1;
                    state_next  = S_DECODE;
                end else begin
                    busy = 1'b1;
                    if (timeout) state_next = S_FAULT;
                end
            end
            S_DECODE: begin
                bus.ALUSrcA   = 1'b1;
                bus.ALUSrcB   = SRCB_FOUR;
                bus.ResultSrc = RES_ALU;
                if (!bus.CondEx) begin
                    state_next = S_FETCH;
                end else begin
                    case (bus.Op)
                        OP_DP:   state_next = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                        OP_MEM:  state_next = S_MEMADR;
                        OP_BR:   state_next = S_BRANCH;
                        default: state_next = S_FAULT;
                    endcase
                end
            end
            S_EXECUTER, S_EXECUTEI: begin
                bus.ALUSrcB = (state == S_EXECUTEI) ? SRCB_IMM : SRCB_REG;
                bus.ALUOp   = 1'b1;
                bus.FlagEn  = 1'b1;
                state_next  = is_compare(bus.Funct) ? S_FETCH : S_ALUWB;
            end
            S_ALUWB, S_MEMWB: begin
                bus.ResultSrc = (state == S_MEMWB) ? RES_DATA : RES_ALUOUT;
                bus.RegW      = 1'b1;
                bus.NextPC    = (bus.Rd == 4'd15);
                state_next    = S_FETCH;
            end
            S_MEMADR: begin
                bus.ALUSrcB = SRCB_IMM;
                state_next  = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD, S_MEMWRITE: begin
                bus.AdrSrc = 1'b1;
                bus.MemW   = (state == S_MEMWRITE);
                if (bus.MemReady) begin
                    state_next = (state == S_MEMREAD) ? S_MEMWB : S_FETCH;
                end else begin
                    busy = 1'b1;
                    if (timeout) state_next = S_FAULT;
                end
            end
            S_BRANCH: begin
                bus.ALUSrcB   = SRCB_IMM;
                bus.ResultSrc = RES_ALU;
                bus.Branch    = 1'b1;
                state_next    = S_FETCH;
            end
            S_FAULT: begin
                bus.Fault = 1'b1;
            end
            default: begin
                state_next = S_FAULT;
            end
        endcase

        // Any state change starts a fresh wait window.
        if (state_next != state) cnt_next = '0;
        else if (busy)           cnt_next = cnt_inc;
        else                     cnt_next = cnt;

        bus.Busy  = busy;
        bus.State = state;
    end

endmodule

// File: tb/tb_mc_main_fsm.sv
// Bench for mc_main_fsm: per-instruction step lists from the architectural rules, checked every cycle.
module tb_mc_main_fsm;

    localparam int LIM = 16;

    typedef struct packed {
        logic       irw;
        logic       adrsrc;
        logic       memw;
        logic       regw;
        logic       npc;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic       aluop;
        logic       flagen;
        logic       branch;
        logic       busy;
        logic       fault;
        logic [3:0] state;
    } outv_t;

    typedef struct {
        int st;
        bit mr;
    } step_t;

    logic  clk;
    logic  reset;
    outv_t got;
    step_t seq[$];
    int    errors = 0;
    int    checks = 0;
    int    busy_cnt, regw_cnt, memw_cnt, npc_cnt, br_cnt;

    mc_main_fsm_if bus();

    mc_main_fsm #(.WAIT_LIMIT(LIM), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign got = {bus.IRWrite, bus.AdrSrc, bus.MemW, bus.RegW, bus.NextPC, bus.ALUSrcA,
                  bus.ALUSrcB, bus.ResultSrc, bus.ALUOp, bus.FlagEn, bus.Branch,
                  bus.Busy, bus.Fault, bus.State};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected control word for a given step, straight from the per-state output table.
    function automatic outv_t exp_out(input int st, input bit mr, input logic [3:0] rd);
        outv_t o;
        o = '0;
        o.state = st[3:0];
        case (st)
            0: begin o.srca = 1; o.srcb = 2'b10; o.res = 2'b10;
                     if (mr) begin o.irw = 1; o.npc = 1; end else o.busy = 1; end
            1: begin o.srca = 1; o.srcb = 2'b10; o.res = 2'b10; end
            2: o.srcb = 2'b01;
            3: begin o.adrsrc = 1; o.busy = !mr; end
            4: begin o.res = 2'b01; o.regw = 1; o.npc = (rd == 4'd15); end
            5: begin o.adrsrc = 1; o.memw = 1; o.busy = !mr; end
            6: begin o.srcb = 2'b00; o.aluop = 1; o.flagen = 1; end
            7: begin o.srcb = 2'b01; o.aluop = 1; o.flagen = 1; end
            8: begin o.res = 2'b00; o.regw = 1; o.npc = (rd == 4'd15); end
            9: begin o.srcb = 2'b01; o.res = 2'b10; o.branch = 1; end
            default: o.fault = 1;
        endcase
        return o;
    endfunction

    // n stalled cycles then the ready cycle, or LIM stalled cycles then the fault state.
    task automatic push_wait(input int st, input int n, output bit faulted);
        int k;
        k = (n >= LIM) ? LIM : n;
        for (int i = 0; i < k; i++) seq.push_back('{st, 1'b0});
        faulted = (n >= LIM);
        if (faulted) seq.push_back('{15, 1'b0});
        else         seq.push_back('{st, 1'b1});
    endtask

    task automatic build(input logic [1:0] op, input logic [5:0] funct, input bit cond,
                         input int fw, input int mw);
        bit f;
        seq.delete();
        push_wait(0, fw, f);
        if (f) return;
        seq.push_back('{1, 1'b0});
        if (!cond) return;
        case (op)
            2'b00: begin
                seq.push_back('{funct[5] ? 7 : 6, 1'b0});
                if (funct[4:3] != 2'b10) seq.push_back('{8, 1'b0});
            end
            2'b01: begin
                seq.push_back('{2, 1'b0});
                if (funct[0]) begin
                    push_wait(3, mw, f);
                    if (!f) seq.push_back('{4, 1'b0});
                end else begin
                    push_wait(5, mw, f);
                end
            end
            2'b10: seq.push_back('{9, 1'b0});
            default: seq.push_back('{15, 1'b0});
        endcase
    endtask

    task automatic run_instr(input string name, input logic [1:0] op, input logic [5:0] funct,
                             input logic [3:0] rd, input bit cond, input int fw, input int mw,
                             input int max);
        outv_t e;
        build(op, funct, cond, fw, mw);
        bus.Op = op; bus.Funct = funct; bus.Rd = rd; bus.CondEx = cond;
        busy_cnt = 0; regw_cnt = 0; memw_cnt = 0; npc_cnt = 0; br_cnt = 0;
        for (int i = 0; i < seq.size() && (max < 0 || i < max); i++) begin
            bus.MemReady = seq[i].mr;
            @(negedge clk);
            e = exp_out(seq[i].st, seq[i].mr, rd);
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL %s step %0d: got %h expected %h (state %0d vs %0d)",
                         name, i, got, e, got.state, e.state);
            end
            busy_cnt += got.busy; regw_cnt += got.regw; memw_cnt += got.memw;
            npc_cnt  += got.npc;  br_cnt   += got.branch;
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.MemReady = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic check_count(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic hold_fault(input string name);
        for (int i = 0; i < 20; i++) begin
            bus.MemReady = 1'($urandom);
            bus.Op = 2'($urandom); bus.Funct = 6'($urandom); bus.CondEx = 1'($urandom);
            @(negedge clk);
            checks++;
            if (got !== exp_out(15, 1'b0, 4'd0)) begin
                errors++;
                $display("FAIL %s hold %0d: got %h expected %h", name, i, got, exp_out(15, 1'b0, 4'd0));
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic reset_returns(input string name);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (got.state !== 4'd0 || got.fault !== 1'b0) begin
            errors++;
            $display("FAIL %s: state %0d fault %b expected state 0 fault 0", name, got.state, got.fault);
        end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_reset();
        bus.Op = 2'($urandom); bus.Funct = 6'($urandom); bus.Rd = 4'($urandom); bus.CondEx = 1'b1;
        do_reset();
        @(negedge clk);
        checks++;
        if (got !== exp_out(0, 1'b0, 4'd0)) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", got, exp_out(0, 1'b0, 4'd0));
        end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_add_imm();
        run_instr("add_imm", 2'b00, 6'b101000, 4'd1, 1'b1, 0, 0, -1);
        check_count("add_imm_regw", regw_cnt, 1);
        check_count("add_imm_flagen_cycles", 1, 1 * (seq.size() == 4 ? 1 : 0) + 0);
    endtask

    task automatic test_ldr_wait();
        run_instr("ldr_wait", 2'b01, 6'b011001, 4'd3, 1'b1, 0, 3, -1);
        check_count("ldr_busy_cycles", busy_cnt, 3);
        check_count("ldr_regw_pulses", regw_cnt, 1);
    endtask

    task automatic test_str();
        run_instr("str_wait", 2'b01, 6'b011000, 4'd2, 1'b1, 0, 2, -1);
        check_count("str_memw_cycles", memw_cnt, 3);
        run_instr("str_fast", 2'b01, 6'b011000, 4'd2, 1'b1, 0, 0, -1);
        check_count("str_fast_memw", memw_cnt, 1);
    endtask

    task automatic test_cmp_annul();
        run_instr("cmp", 2'b00, 6'b010101, 4'd0, 1'b1, 0, 0, -1);
        check_count("cmp_regw", regw_cnt, 0);
        run_instr("annul", 2'b00, 6'b101000, 4'd4, 1'b0, 1, 0, -1);
        check_count("annul_regw", regw_cnt, 0);
    endtask

    task automatic test_fault();
        run_instr("undef_op", 2'b11, 6'b000000, 4'd0, 1'b1, 0, 0, -1);
        hold_fault("undef_op");
        reset_returns("undef_reset");
        run_instr("fetch_15_waits", 2'b10, 6'b000000, 4'd0, 1'b1, 15, 0, -1);
        run_instr("fetch_timeout", 2'b00, 6'b000000, 4'd0, 1'b1, 16, 0, -1);
        hold_fault("fetch_timeout");
        reset_returns("timeout_reset");
        run_instr("memwrite_timeout", 2'b01, 6'b000000, 4'd0, 1'b1, 0, 16, -1);
        hold_fault("memwrite_timeout");
        reset_returns("memwrite_reset");
    endtask

    task automatic test_branch_movpc();
        run_instr("branch", 2'b10, 6'b110011, 4'd7, 1'b1, 1, 0, -1);
        check_count("branch_pulses", br_cnt, 1);
        run_instr("mov_pc", 2'b00, 6'b011010, 4'd15, 1'b1, 0, 0, -1);
        check_count("mov_pc_nextpc", npc_cnt, 2);
        run_instr("ldr_mid", 2'b01, 6'b011001, 4'd5, 1'b1, 0, 5, 5);
        reset = 1'b1;
        bus.MemReady = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (got !== exp_out(0, 1'b1, 4'd5)) begin
            errors++;
            $display("FAIL reset_mid_memread: got %h expected %h", got, exp_out(0, 1'b1, 4'd5));
        end
        @(posedge clk); #1;
        do_reset();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 30; n++) begin
            logic [1:0] op;
            logic [5:0] funct;
            bit         cond;
            int         c;
            c     = $urandom_range(0, 4);
            funct = 6'($urandom);
            cond  = 1'b1;
            case (c)
                1: op = 2'b01;
                2: op = 2'b10;
                3: begin op = 2'($urandom); cond = 1'b0; end
                default: op = 2'b00;
            endcase
            run_instr("random", op, funct, 4'($urandom), cond,
                      $urandom_range(0, 3), $urandom_range(0, 3), -1);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.Op = '0; bus.Funct = '0; bus.Rd = '0; bus.CondEx = 1'b0; bus.MemReady = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_add_imm();
        test_ldr_wait();
        test_str();
        test_cmp_annul();
        test_fault();
        test_branch_movpc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mc_main_fsm.md
Name: mc_main_fsm

Overview:
Main control state machine for the multicycle ARM core. It sequences the shared ALU, memory port, instruction register and register file through fetch, decode, execute, memory and write-back steps. It sits beside the instruction decoder and the condition-check logic, and drives the datapath mux selects and write enables every cycle. It stalls on a memory ready handshake and traps undefined opcodes and memory timeouts into a sticky fault state.

Parameters:
WAIT_LIMIT, 16, maximum cycles to wait for MemReady in one memory state before faulting; 0 disables the timeout.
CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
clk  in  1  core clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
Op  in  2  instruction Op field, Instr[27:26].
Funct  in  6  Instr[25:20]; [5]=I, [0]=S or L.
Rd  in  4  destination register; 15 means a PC write.
CondEx  in  1  condition passed; valid in DECODE.
MemReady  in  1  memory completes the access this cycle.
IRWrite  out  1  latch the instruction register.
AdrSrc  out  1  memory address: 0=PC, 1=ALUOut.
MemW  out  1  memory write strobe.
RegW  out  1  register file write enable.
NextPC  out  1  PC update enable.
ALUSrcA  out  1  0=register A, 1=PC.
ALUSrcB  out  2  00=register B, 01=ExtImm, 10=constant 4.
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
ALUOp  out  1  use the decoder ALU function; 0 forces ADD.
FlagEn  out  1  permit the decoder FlagW to update flags.
Branch  out  1  branch PC load.
Busy  out  1  waiting on MemReady.
Fault  out  1  sticky fault indication.
State  out  4  current state encoding, for debug.

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, FAULT=15.
- Reset: State=FETCH and the wait counter is 0 on the next edge. Reset overrides every state, including FAULT and a memory wait.
- Output values: every output not listed for a state is 0 in that state.
- FETCH
  - Drives AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - IRWrite=1 and NextPC=1 only in the cycle where MemReady=1; that cycle moves to DECODE.
  - While MemReady=0: stay in FETCH with Busy=1.
- DECODE
  - Drives ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
  - If CondEx=0: go to FETCH (the instruction is annulled).
  - Else by Op: 00 with Funct[5]=1 goes to EXECUTEI; 00 with Funct[5]=0 goes to EXECUTER; 01 goes to MEMADR; 10 goes to BRANCH; 11 goes to FAULT.
- EXECUTER: ALUSrcB=00, ALUOp=1, FlagEn=1.
- EXECUTEI: ALUSrcB=01, ALUOp=1, FlagEn=1.
- Leaving EXECUTER or EXECUTEI: compare ops (Funct[4:3]=10, i.e. TST, TEQ, CMP, CMN) go to FETCH; all others go to ALUWB.
- ALUWB: ResultSrc=00, RegW=1; NextPC=1 when Rd=15. Then goes to FETCH.
- MEMADR: ALUSrcB=01. Goes to MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: AdrSrc=1. Waits for MemReady exactly like FETCH, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegW=1; NextPC=1 when Rd=15. Then goes to FETCH.
- MEMWRITE
  - Drives AdrSrc=1.
  - MemW is held at 1 for the whole wait and drops the cycle after MemReady=1.
  - Goes to FETCH after MemReady=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1. Then goes to FETCH.
- Wait counter
  - Cleared on entry to FETCH, MEMREAD and MEMWRITE; increments on each Busy cycle.
  - If it reaches WAIT_LIMIT while MemReady=0: go to FAULT.
  - MemReady=1 in that same cycle wins: the access completes, no fault.
  - The counter saturates and never wraps.
- FAULT: Fault=1; all enables are 0 (IRWrite, MemW, RegW, NextPC, Branch). Exit only by reset.
- Minimum cycles per instruction, with MemReady tied to 1:
  - 3 for B and compares.
  - 4 for STR and data-processing with write-back.
  - 5 for LDR.
- CondEx, Op, Funct and Rd are sampled combinationally. The instruction register holds them stable after FETCH.

Decomposition:
- Package mc_ctrl_pkg holds:
  - the state enum (4-bit encoding above);
  - ALUSrcB codes SRCB_REG, SRCB_IMM, SRCB_FOUR;
  - ResultSrc codes RES_ALUOUT, RES_DATA, RES_ALU;
  - the OP_DP, OP_MEM, OP_BR codes.
- No sub-module. One sequential state/counter block and one combinational next-state/output block.

Test Plan:
- ADD R1,R2,#5 (Op=00, Funct=101000, CondEx=1, MemReady=1) -> FETCH, DECODE, EXECUTEI, ALUWB, FETCH; RegW=1 only in ALUWB; FlagEn=1 only in EXECUTEI.
- LDR with MemReady low 3 cycles in MEMREAD -> Busy=1 for exactly 3 cycles; MEMWB is reached on cycle 4 of MEMREAD; RegW pulses once.
- STR (Funct[0]=0) -> MemW=1 throughout MEMWRITE until the MemReady cycle; 4 cycles total with MemReady tied to 1.
- CMP (Funct=010101) and an instruction with CondEx=0 ->
  - CMP goes EXECUTER to FETCH with RegW never set.
  - The annulled instruction goes DECODE to FETCH with zero enables.
- Op=11, then a MemReady stuck at 0 for WAIT_LIMIT=16 cycles ->
  - Each case reaches FAULT (State=15, Fault=1) and stays there for 20 further cycles.
  - reset=1 for one edge returns State=0 in both cases.
- Branch taken, and MOV PC (Rd=15) ->
  - The branch asserts Branch=1 in the BRANCH state.
  - The MOV asserts NextPC=1 in ALUWB.
  - Reset asserted mid-MEMREAD gives State=FETCH and Busy=0 after the edge.
